mc_control: RTL and testbench
=============================

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 The block SHALL have these ports, listed as name, direction, width, meaning.
REQ-002 CLK  in  1  single clock; all state changes on the rising edge.
REQ-003 RST  in  1  asynchronous, active-high reset.
REQ-004 Cond  in  4  instruction bits [31:28], condition field.
REQ-005 Op  in  2  instruction bits [27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined.
REQ-006 Funct  in  6  instruction bits [25:20]: [5] immediate flag I, [4:1] cmd, [0] S for data-processing or L for memory.
REQ-007 Rd  in  4  instruction bits [15:12], destination register.
REQ-008 ALUFlags  in  4  NZCV from the ALU, current cycle.
REQ-009 PCWrite, MemWrite, IRWrite, RegWrite  out  1 each  write enables; RegWrite drives the register-file WEN.
REQ-010 AdrSrc  out  1  memory address select (0 = PC, 1 = ALU result).
REQ-011 ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc  out  2 each  datapath selects.
REQ-012 State  out  4  current FSM state, for debug.

Function
REQ-013 State encoding SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9; codes 10-15 SHALL go to FETCH on the next edge.
REQ-014 Transitions SHALL be:
- FETCH -> DECODE.
- DECODE -> EXECR (Op=00, I=0), EXECI (Op=00, I=1), MEMADR (Op=01), BRANCH (Op=10), or FETCH (Op=11).
- MEMADR -> MEMRD if L=1, else MEMWR.
- MEMRD -> MEMWB -> FETCH; MEMWR -> FETCH.
- EXECR and EXECI -> ALUWB -> FETCH.
- BRANCH -> FETCH.
REQ-015 Per-state raw controls SHALL be (unlisted controls are 0):
- FETCH: IRWrite=1, NextPC=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUControl=ADD.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
- MEMADR: ALUSrcB=01.
- MEMRD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegW=1.
- MEMWR: AdrSrc=1, MemW=1.
- EXECR: ALUOp=1, ALUSrcB=00.
- EXECI: ALUOp=1, ALUSrcB=01.
- ALUWB: RegW=1.
- BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
REQ-016 With ALUOp=1, cmd SHALL decode as: 0100 ADD->00, 0010 SUB->01, 0000 AND->10, 1100 ORR->11, 1010 CMP->01 with NoWrite=1; any other cmd SHALL give 00 with all flag writes disabled. With ALUOp=0, ALUControl SHALL be 00.
REQ-017 FlagW[1] (NZ) SHALL equal S; FlagW[0] (CV) SHALL equal S AND cmd in {ADD, SUB}; CMP SHALL force both FlagW bits to 1.
REQ-018 A 4-bit NZCV flag register SHALL load ALUFlags on the rising edge that ends EXECR or EXECI, per FlagW group, only when CondEx=1.
REQ-019 CondEx SHALL be evaluated combinationally from Cond and the stored flags:
- EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
- HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
- AL 1; Cond=1111 gives 0.
REQ-020 The qualified write enables SHALL be:
- PCS = (Rd==15 & RegW) | Branch.
- RegWrite = RegW & CondEx & !NoWrite & (Rd!=15).
- MemWrite = MemW & CondEx.
- PCWrite = NextPC | (PCS & CondEx & !NoWrite).
- A write-back to R15 SHALL go only to the PC, never to the register file.
REQ-021 ImmSrc SHALL equal Op; RegSrc[0] SHALL equal (Op==10); RegSrc[1] SHALL equal (Op==01), in every state.
REQ-022 Instruction fields SHALL be held stable by the instruction register from DECODE onward, so no field capture occurs inside this block.

Reset
REQ-023 Asserting RST SHALL immediately force State=FETCH and flags to 0000, independent of CLK.
REQ-024 While RST=1, PCWrite, MemWrite, IRWrite and RegWrite SHALL be 0.
REQ-025 The first rising edge after RST falls SHALL be a FETCH cycle.
REQ-026 RST asserted mid-instruction SHALL abort the instruction with no further register, memory or flag write.

Verification
REQ-027 ADD with S=1, Rd=3, Cond=1110, ALUFlags=0100:
- State sequence is 0,1,6,8,0.
- RegWrite=1 only in ALUWB.
- Flags become 0100 after EXECR.
REQ-028 LDR (Op=01, L=1, Rd=2):
- State sequence is 0,1,2,3,4,0.
- AdrSrc=1 in MEMRD.
- RegWrite=1 with ResultSrc=01 in MEMWB.
REQ-029 STR with Cond=0000 and Z=0:
- State sequence is 0,1,2,5,0.
- MemWrite stays 0.
REQ-030 CMP setting Z=1, then BEQ:
- CMP gives RegWrite=0 and flags Z=1.
- BEQ gives PCWrite=1 in BRANCH.
- BNE gives PCWrite=0 in BRANCH.
REQ-031 ADD with Rd=15: in ALUWB, RegWrite=0 and PCWrite=1.
REQ-032 RST pulsed during MEMWR:
- State=0 immediately.
- MemWrite=0 immediately.
- Flags=0000.
- Op=11 afterwards gives sequence 0,1,0 with no writes.

Source files
------------

// File: rtl/mc_control.sv
// Multicycle ARM-subset main controller: instruction-sequencing FSM, ALU decoder,
// NZCV flag register and condition check that qualifies every architectural write.
module mc_control (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  typedef struct packed {
    logic       irw;
    logic       nextpc;
    logic       adrsrc;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       aluop;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] ressrc;
  } ctrl_t;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // Raw (unqualified) controls asserted in each state.
  function automatic ctrl_t ctrl_of(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.irw    = 1'b1;
        c.nextpc = 1'b1;
        c.srca   = 2'b01;
        c.srcb   = 2'b10;
        c.ressrc = 2'b10;
      end
      DECODE: begin
        c.srca   = 2'b01;
        c.srcb   = 2'b10;
        c.ressrc = 2'b10;
      end
      MEMADR: c.srcb = 2'b01;
      MEMRD:  c.adrsrc = 1'b1;
      MEMWB: begin
        c.ressrc = 2'b01;
        c.regw   = 1'b1;
      end
      MEMWR: begin
        c.adrsrc = 1'b1;
        c.memw   = 1'b1;
      end
      EXECR: c.aluop = 1'b1;
      EXECI: begin
        c.aluop = 1'b1;
        c.srcb  = 2'b01;
      end
      ALUWB: c.regw = 1'b1;
      BRANCH: begin
        c.srcb   = 2'b01;
        c.ressrc = 2'b10;
        c.branch = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t     state_q, state_d;
  ctrl_t      ctrl_q;
  logic [3:0] flags_q;
  logic [3:0] cmd;
  logic       s_bit;
  logic [1:0] alu_ctl;
  logic [1:0] flag_w;
  logic       no_write;
  logic       cond_ex;
  logic       pcs;
  logic       exec;

  assign cmd   = Funct[4:1];
  assign s_bit = Funct[0];
  assign exec  = (state_q == EXECR) || (state_q == EXECI);

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (Op)
          2'b00:   state_d = Funct[5] ? EXECI : EXECR;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: state_d = Funct[0] ? MEMRD : MEMWR;
      MEMRD:  state_d = MEMWB;
      EXECR:  state_d = ALUWB;
      EXECI:  state_d = ALUWB;
      default: state_d = FETCH;
    endcase
  end

  // NoWrite must persist into ALUWB, so it is decoded from the held opcode, not ALUOp.
  always_comb begin
    alu_ctl  = 2'b00;
    flag_w   = 2'b00;
    no_write = (Op == 2'b00) && (cmd == CMD_CMP);
    if (ctrl_q.aluop) begin
      case (cmd)
        CMD_ADD: begin alu_ctl = 2'b00; flag_w = {s_bit, s_bit}; end
        CMD_SUB: begin alu_ctl = 2'b01; flag_w = {s_bit, s_bit}; end
        CMD_AND: begin alu_ctl = 2'b10; flag_w = {s_bit, 1'b0}; end
        CMD_ORR: begin alu_ctl = 2'b11; flag_w = {s_bit, 1'b0}; end
        CMD_CMP: begin alu_ctl = 2'b01; flag_w = 2'b11; end
        default: begin alu_ctl = 2'b00; flag_w = 2'b00; end
      endcase
    end
  end

  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags_q;
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= FETCH;
      ctrl_q  <= ctrl_of(FETCH);
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_of(state_d);
      if (exec && cond_ex && flag_w[1]) flags_q[3:2] <= ALUFlags[3:2];
      if (exec && cond_ex && flag_w[0]) flags_q[1:0] <= ALUFlags[1:0];
    end
  end

  // Write enables are masked by RST directly so an abort takes effect without a clock.
  assign pcs      = ((Rd == 4'hF) & ctrl_q.regw) | ctrl_q.branch;
  assign PCWrite  = ~RST & (ctrl_q.nextpc | (pcs & cond_ex & ~no_write));
  assign RegWrite = ~RST & ctrl_q.regw & cond_ex & ~no_write & (Rd != 4'hF);
  assign MemWrite = ~RST & ctrl_q.memw & cond_ex;
  assign IRWrite  = ~RST & ctrl_q.irw;

  assign AdrSrc     = ctrl_q.adrsrc;
  assign ResultSrc  = ctrl_q.ressrc;
  assign ALUSrcA    = ctrl_q.srca;
  assign ALUSrcB    = ctrl_q.srcb;
  assign ALUControl = alu_ctl;
  assign ImmSrc     = Op;
  assign RegSrc     = {Op == 2'b01, Op == 2'b10};
  assign State      = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: directed scenarios and random instructions checked against
// an instruction-level model (state path per class, NZCV register, condition table).
module tb_mc_control;

  logic       CLK;
  logic       RST;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite, MemWrite, IRWrite, RegWrite, AdrSrc;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  logic [3:0] State;

  int checks = 0;
  int errors = 0;
  logic [3:0] mflags;

  mc_control dut (
    .CLK(CLK), .RST(RST), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .AdrSrc(AdrSrc),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .State(State)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_outputs(input int s, input logic [3:0] cond, input logic [1:0] op,
                               input logic [5:0] funct, input logic [3:0] rd);
    bit ce, cmp, wb, e_pcw, e_rw;
    logic [1:0] e_alu, e_rs, e_sa, e_sb;
    logic [3:0] cmd;
    cmd = funct[4:1];
    ce  = cond_holds(cond, mflags);
    cmp = (op == 2'b00) && (cmd == 4'b1010);
    wb  = (s == 4) || (s == 8);
    e_rw  = wb && ce && !cmp && (rd != 4'd15);
    e_pcw = (s == 0) || ((((wb && rd == 4'd15)) || s == 9) && ce && !cmp);
    e_alu = 2'b00;
    if (s == 6 || s == 7) begin
      if (cmd == 4'b0010 || cmd == 4'b1010) e_alu = 2'b01;
      else if (cmd == 4'b0000) e_alu = 2'b10;
      else if (cmd == 4'b1100) e_alu = 2'b11;
    end
    e_rs = (s == 0 || s == 1 || s == 9) ? 2'b10 : (s == 4) ? 2'b01 : 2'b00;
    e_sa = (s == 0 || s == 1) ? 2'b01 : 2'b00;
    e_sb = (s == 0 || s == 1) ? 2'b10 : (s == 2 || s == 7 || s == 9) ? 2'b01 : 2'b00;
    chk($sformatf("State@%0d", s), State, s);
    chk($sformatf("IRWrite@%0d", s), IRWrite, s == 0);
    chk($sformatf("MemWrite@%0d", s), MemWrite, (s == 5) && ce);
    chk($sformatf("RegWrite@%0d", s), RegWrite, e_rw);
    chk($sformatf("PCWrite@%0d", s), PCWrite, e_pcw);
    chk($sformatf("AdrSrc@%0d", s), AdrSrc, (s == 3) || (s == 5));
    chk($sformatf("ResultSrc@%0d", s), ResultSrc, e_rs);
    chk($sformatf("ALUSrcA@%0d", s), ALUSrcA, e_sa);
    chk($sformatf("ALUSrcB@%0d", s), ALUSrcB, e_sb);
    chk($sformatf("ALUControl@%0d", s), ALUControl, e_alu);
    chk($sformatf("ImmSrc@%0d", s), ImmSrc, op);
    chk($sformatf("RegSrc@%0d", s), RegSrc, {op == 2'b01, op == 2'b10});
  endtask

  // Model of the flag register update at the end of an execute cycle.
  task automatic update_flags(input logic [3:0] cond, input logic [5:0] funct, input logic [3:0] alf);
    bit nz, cv, s;
    logic [3:0] cmd;
    cmd = funct[4:1];
    s   = funct[0];
    nz = 0; cv = 0;
    if (cmd == 4'b1010) begin nz = 1; cv = 1; end
    else if (cmd == 4'b0100 || cmd == 4'b0010) begin nz = s; cv = s; end
    else if (cmd == 4'b0000 || cmd == 4'b1100) nz = s;
    if (cond_holds(cond, mflags)) begin
      if (nz) mflags[3:2] = alf[3:2];
      if (cv) mflags[1:0] = alf[1:0];
    end
  endtask

  // Called at a falling edge with the DUT in FETCH; returns at the next FETCH's falling
  // edge, or just after checking step abort_at (left mid-cycle) when abort_at >= 0.
  task automatic do_instr(input logic [3:0] cond, input logic [1:0] op, input logic [5:0] funct,
                          input logic [3:0] rd, input logic [3:0] alf, input int abort_at);
    int seq[$];
    Cond = cond; Op = op; Funct = funct; Rd = rd; ALUFlags = alf;
    seq = {0, 1};
    case (op)
      2'b00: begin seq.push_back(funct[5] ? 7 : 6); seq.push_back(8); end
      2'b01: begin
        seq.push_back(2);
        if (funct[0]) begin seq.push_back(3); seq.push_back(4); end
        else seq.push_back(5);
      end
      2'b10: seq.push_back(9);
      default: ;
    endcase
    for (int i = 0; i < seq.size(); i++) begin
      if (i > 0) @(negedge CLK);
      #1;
      check_outputs(seq[i], cond, op, funct, rd);
      if (seq[i] == 6 || seq[i] == 7) update_flags(cond, funct, alf);
      if (i == abort_at) return;
    end
    @(negedge CLK);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_State"}, State, 4'd0);
    chk({tag, "_PCWrite"}, PCWrite, 1'b0);
    chk({tag, "_MemWrite"}, MemWrite, 1'b0);
    chk({tag, "_IRWrite"}, IRWrite, 1'b0);
    chk({tag, "_RegWrite"}, RegWrite, 1'b0);
  endtask

  initial begin
    logic [3:0] cmds [5];
    RST = 1'b1; Cond = 4'hE; Op = 2'b11; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'd0;
    mflags = 4'b0000;
    #1;
    check_reset_outputs("por");
    @(posedge CLK); #1;
    check_reset_outputs("por_clk");
    @(negedge CLK);
    RST = 1'b0;

    // ADD S=1 Rd=3 AL, flags 0100; then BEQ taken and BNE not taken
    do_instr(4'hE, 2'b00, 6'b001001, 4'd3, 4'b0100, -1);
    do_instr(4'h0, 2'b10, 6'b100000, 4'd0, 4'b0000, -1);
    do_instr(4'h1, 2'b10, 6'b100000, 4'd0, 4'b0000, -1);
    // LDR Rd=2
    do_instr(4'hE, 2'b01, 6'b011001, 4'd2, 4'b0000, -1);
    // Clear Z, then STREQ must not write
    do_instr(4'hE, 2'b00, 6'b001001, 4'd4, 4'b0000, -1);
    do_instr(4'h0, 2'b01, 6'b011000, 4'd5, 4'b0000, -1);
    // CMP sets Z, then BEQ / BNE
    do_instr(4'hE, 2'b00, 6'b010101, 4'd0, 4'b0100, -1);
    do_instr(4'h0, 2'b10, 6'b100000, 4'd0, 4'b0000, -1);
    do_instr(4'h1, 2'b10, 6'b100000, 4'd0, 4'b0000, -1);
    // ADD to R15 writes the PC only; immediate form too
    do_instr(4'hE, 2'b00, 6'b001000, 4'd15, 4'b0000, -1);
    do_instr(4'hE, 2'b00, 6'b101000, 4'd15, 4'b0000, -1);

    // STR aborted by reset in MEMWR, with Z=1 stored beforehand
    do_instr(4'hE, 2'b00, 6'b010101, 4'd0, 4'b0100, -1);
    do_instr(4'hE, 2'b01, 6'b011000, 4'd7, 4'b0000, 3);
    #2 RST = 1'b1;
    mflags = 4'b0000;
    #1;
    check_reset_outputs("abort");
    @(posedge CLK); #1;
    check_reset_outputs("abort_hold");
    @(negedge CLK);
    RST = 1'b0;
    do_instr(4'hE, 2'b11, 6'b000000, 4'd0, 4'b0000, -1);
    do_instr(4'h0, 2'b10, 6'b100000, 4'd0, 4'b0000, -1);
    do_instr(4'h1, 2'b10, 6'b100000, 4'd0, 4'b0000, -1);

    // Random instruction stream
    cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000;
    cmds[3] = 4'b1100; cmds[4] = 4'b1010;
    for (int n = 0; n < 150; n++) begin
      logic [3:0] c, rd, cmd, alf;
      logic [1:0] op;
      logic [5:0] f;
      c   = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom_range(0, 15));
      op  = 2'($urandom_range(0, 3));
      rd  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
      alf = 4'($urandom_range(0, 15));
      cmd = ($urandom_range(0, 5) == 5) ? 4'($urandom_range(0, 15)) : cmds[$urandom_range(0, 4)];
      f   = (op == 2'b00) ? {1'($urandom_range(0, 1)), cmd, 1'($urandom_range(0, 1))}
                          : 6'($urandom_range(0, 63));
      do_instr(c, op, f, rd, alf, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
